// File: rtl/swap_controller_pkg.sv
// Shared types and constants for the swap controller and the counter block it feeds.
package swap_controller_pkg;

  // Same width as the downstream dual counter block.
  localparam int COUNT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PULSE        = 2'd1,
    LOCKOUT      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/swap_controller_if.sv
// Button inputs and counter-block control outputs of the swap controller.
interface swap_controller_if
  import swap_controller_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF
) ();

  logic               btn_swap;
  logic               btn_enable;
  logic               swap;
  logic               enable;
  logic [COUNT_W-1:0] swap_count;
  logic               busy;

  // master drives the buttons and observes the controls; slave is the controller.
  modport master (
    output btn_swap, btn_enable,
    input  swap, enable, swap_count, busy
  );

  modport slave (
    input  btn_swap, btn_enable,
    output swap, enable, swap_count, busy
  );

endinterface

// File: rtl/swap_controller_debouncer.sv
// Two-flop synchronizer plus stability counter for one raw push-button; emits the
// accepted level and a one-cycle rising-edge strobe.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn,
  output logic deb,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          meta;
  logic          sync;
  logic          deb_q;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, exactly like the hardware.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      deb   <= 1'b0;
      deb_q <= 1'b0;
      cnt   <= '0;
    end else begin
      meta  <= btn;
      sync  <= meta;
      deb_q <= deb;
      if (sync == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb <= sync;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign rise = deb & ~deb_q;

endmodule

// File: rtl/swap_controller.sv
// Turns two bouncy buttons into a toggled enable level and a lockout-guarded,
// single-cycle swap pulse with a wrap-around issue count.
module swap_controller
  import swap_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 8,
  parameter int COUNT_W         = COUNT_W_DEF
) (
  input logic              clock,
  input logic              reset_n,
  swap_controller_if.slave bus
);

  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  logic               sw_deb, sw_rise;
  logic               en_deb, en_rise;
  logic               unused_en_deb;
  logic               enable_q;
  logic [COUNT_W-1:0] count;
  state_t             state, state_n;
  logic [LW-1:0]      lock_cnt, lock_cnt_n;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_deb (
    .clock   (clock),
    .reset_n (reset_n),
    .btn     (bus.btn_swap),
    .deb     (sw_deb),
    .rise    (sw_rise)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_en_deb (
    .clock   (clock),
    .reset_n (reset_n),
    .btn     (bus.btn_enable),
    .deb     (en_deb),
    .rise    (en_rise)
  );

  // The enable button acts on press edges only; its level has no consumer.
  assign unused_en_deb = en_deb;

  // NOTE: every signal driven here gets a default first, so no path through the
  // case can leave it unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    lock_cnt_n = lock_cnt;
    case (state)
      IDLE: begin
        // Qualified by the registered enable, i.e. the value before any
        // toggle landing on the same edge.
        if (sw_rise) state_n = enable_q ? PULSE : WAIT_RELEASE;
      end
      PULSE: begin
        lock_cnt_n = LW'(LOCKOUT_CYCLES - 1);
        state_n    = LOCKOUT;
      end
      LOCKOUT: begin
        if (lock_cnt == '0) state_n = WAIT_RELEASE;
        else                lock_cnt_n = lock_cnt - LW'(1);
      end
      WAIT_RELEASE: begin
        if (!sw_deb) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch and has
  // no effect between edges.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      lock_cnt <= '0;
      enable_q <= 1'b0;
      count    <= '0;
    end else begin
      state    <= state_n;
      lock_cnt <= lock_cnt_n;
      if (en_rise)         enable_q <= ~enable_q;
      if (state == PULSE)  count    <= count + COUNT_W'(1);
    end
  end

  // Outputs decode registered state only; no input reaches them combinationally.
  assign bus.swap       = (state == PULSE);
  assign bus.busy       = (state == PULSE) || (state == LOCKOUT);
  assign bus.enable     = enable_q;
  assign bus.swap_count = count;

endmodule
